// File: rtl/conv_pkg.sv
// Shared types and defaults for the 5x5 convolution line-buffer sequencer.
package conv_pkg;

  localparam int K_DEF  = 5;
  localparam int CW_DEF = 8;
  localparam int DW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit offset of coefficient i inside the flattened f_coeff bus.
  function automatic int coef_lsb(input int i, input int cw);
    return cw * i;
  endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// Shadow coefficient register file plus the active bank the buffer sees.
// The active bank only changes on load, so it stays frozen for a whole frame.
module conv_coef_bank
  import conv_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coef_wr,
  input  logic [4:0]          coef_addr,
  input  logic [CW-1:0]       coef_data,
  input  logic                load,
  output logic [K*K*CW-1:0]   f_coeff
);

  localparam int NCOEF = K * K;

  logic [CW-1:0] shadow [NCOEF];

  // Non-blocking update means a load coincident with a write copies the old shadow value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCOEF; i++) shadow[i] <= '0;
      f_coeff <= '0;
    end else begin
      if (coef_wr && (coef_addr < 5'(NCOEF))) shadow[coef_addr] <= coef_data;
      if (load) begin
        for (int i = 0; i < NCOEF; i++) f_coeff[coef_lsb(i, CW) +: CW] <= shadow[i];
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Sequencer for the 5x5 convolution line buffer: feeds pixels, holds coefficients,
// and tags buffer results valid only for windows lying fully inside the image.
module conv_sched
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 6,
  parameter int K       = K_DEF,
  parameter int DW      = DW_DEF,
  parameter int CW      = CW_DEF,
  parameter int BUF_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  input  logic                coef_wr,
  input  logic [4:0]          coef_addr,
  input  logic [CW-1:0]       coef_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [DW-1:0]       pix_data,
  output logic                buf_en,
  output logic [DW-1:0]       buf_d_in,
  output logic [K*K*CW-1:0]   f_coeff,
  input  logic [DW-1:0]       buf_d_out,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic                out_last
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DRN_W = (BUF_LAT > 1) ? $clog2(BUF_LAT) : 1;

  state_t              state, state_nx;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [DRN_W-1:0]    drain_cnt;
  logic                accept, advance, start_acc, clear, at_last, tag_in;
  logic [BUF_LAT-1:0]  tag_v, tag_l;

  assign start_acc = (state == IDLE) && start && !abort;
  assign clear     = (state != IDLE) && abort;
  assign at_last   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign tag_in    = accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc) state_nx = RUN;
      RUN:     if (accept && at_last) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DRN_W'(BUF_LAT - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_comb begin
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    case (state)
      RUN: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        accept    = pix_valid;
        advance   = pix_valid;
      end
      DRAIN: begin
        busy    = 1'b1;
        advance = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign buf_en   = accept;
  assign buf_d_in = accept ? pix_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else if (clear || start_acc) begin
      col       <= '0;
      row       <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        if (col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= at_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // The tag pipe mirrors the buffer latency, so it only moves when the buffer does (or while draining).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v <= '0;
      tag_l <= '0;
    end else if (clear) begin
      tag_v <= '0;
      tag_l <= '0;
    end else if (advance) begin
      for (int i = BUF_LAT - 1; i >= 1; i--) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
      tag_v[0] <= tag_in;
      tag_l[0] <= tag_in && at_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clear || !advance) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= tag_v[BUF_LAT-1];
      out_last  <= tag_v[BUF_LAT-1] && tag_l[BUF_LAT-1];
      if (tag_v[BUF_LAT-1]) out_data <= buf_d_out;
    end
  end

  conv_coef_bank #(
    .K  (K),
    .CW (CW)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .load      (start_acc),
    .f_coeff   (f_coeff)
  );

endmodule
